// File: rtl/pcpi_pkg.sv
// Shared types and constants for the PCPI dispatch block.
//   state_t  : dispatcher FSM states
//   target_t : which co-processor unit an instruction belongs to
//   OPC_OP / F7_MULDIV : RV32 OP opcode and the MULDIV funct7
package pcpi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_M,
        TGT_CUSTOM
    } target_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/pcpi_dispatch_if.sv
// Bundle of all handshake/data signals around the dispatcher.
//   pcpi_* : core request (valid/insn/rs1/rs2) and response (wr/rd/wait/ready)
//   m_*    : request to / response from the M unit
//   c_*    : request to / response from the custom unit
//   timeout_err : sticky abort flag
// Modports:
//   slave  : the dispatcher itself
//   master : the environment (core plus both units)
interface pcpi_dispatch_if;

    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    logic        m_valid;
    logic [31:0] m_instruction;
    logic [31:0] m_rs1;
    logic [31:0] m_rs2;
    logic        m_wr;
    logic [31:0] m_rd;
    logic        m_busy;
    logic        m_ready;

    logic        c_valid;
    logic [31:0] c_instruction;
    logic [31:0] c_rs1;
    logic [31:0] c_rs2;
    logic        c_wr;
    logic [31:0] c_rd;
    logic        c_busy;
    logic        c_ready;

    logic        timeout_err;

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        output m_valid, m_instruction, m_rs1, m_rs2,
        input  m_wr, m_rd, m_busy, m_ready,
        output c_valid, c_instruction, c_rs1, c_rs2,
        input  c_wr, c_rd, c_busy, c_ready,
        output timeout_err
    );

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        input  m_valid, m_instruction, m_rs1, m_rs2,
        output m_wr, m_rd, m_busy, m_ready,
        input  c_valid, c_instruction, c_rs1, c_rs2,
        output c_wr, c_rd, c_busy, c_ready,
        input  timeout_err
    );

endinterface

// File: rtl/pcpi_decode.sv
// Pure combinational instruction classifier.
//   insn   : 32-bit instruction word
//   target : TGT_M for RV32M ops, TGT_CUSTOM for CUSTOM_OPCODE, else TGT_NONE
module pcpi_decode
    import pcpi_pkg::*;
#(
    parameter logic [6:0] CUSTOM_OPCODE = 7'b0001011
) (
    input  logic [31:0] insn,
    output target_t     target
);

    // Middle fields do not influence the routing decision.
    logic insn_unused;
    assign insn_unused = ^insn[24:7];

    always_comb begin
        target = TGT_NONE;
        if (insn[6:0] == OPC_OP && insn[31:25] == F7_MULDIV)
            target = TGT_M;
        else if (insn[6:0] == CUSTOM_OPCODE)
            target = TGT_CUSTOM;
    end

endmodule

// File: rtl/pcpi_dispatch.sv
// Routes PCPI requests from the core to either the M unit or the custom unit,
// returns the unit's result for exactly one cycle, and aborts a unit that
// takes longer than TIMEOUT_CYCLES.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : pcpi_dispatch_if slave modport (core, M unit, custom unit,
//                sticky timeout_err)
module pcpi_dispatch
    import pcpi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [6:0]  CUSTOM_OPCODE  = 7'b0001011
) (
    input logic           clk,
    input logic           reset,
    pcpi_dispatch_if.slave bus
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1024) begin : g_bad_timeout
        $error("pcpi_dispatch: TIMEOUT_CYCLES out of range 2..1024");
    end
    if (CUSTOM_OPCODE == OPC_OP) begin : g_bad_opcode
        $error("pcpi_dispatch: CUSTOM_OPCODE collides with OP opcode");
    end

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_n;
    target_t       cls, tgt;
    logic [31:0]   insn_q, rs1_q, rs2_q, rd_q;
    logic          wr_q;
    logic [CW-1:0] cnt;
    logic          err_q;

    logic          claim, done, expire;
    logic          tgt_ready, tgt_wr;
    logic [31:0]   tgt_rd;
    logic          issue_m, issue_c, in_resp;

    // Busy lines carry no functional meaning for this block.
    logic busy_unused;
    assign busy_unused = bus.m_busy | bus.c_busy;

    pcpi_decode #(.CUSTOM_OPCODE(CUSTOM_OPCODE)) u_decode (
        .insn   (bus.pcpi_insn),
        .target (cls)
    );

    // Only the latched target's response is visible; the other unit is ignored.
    always_comb begin
        tgt_ready = 1'b0;
        tgt_wr    = 1'b0;
        tgt_rd    = '0;
        case (tgt)
            TGT_M: begin
                tgt_ready = bus.m_ready;
                tgt_wr    = bus.m_wr;
                tgt_rd    = bus.m_rd;
            end
            TGT_CUSTOM: begin
                tgt_ready = bus.c_ready;
                tgt_wr    = bus.c_wr;
                tgt_rd    = bus.c_rd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        claim   = 1'b0;
        done    = 1'b0;
        expire  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!reset && bus.pcpi_valid && cls != TGT_NONE) begin
                    claim   = 1'b1;
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A ready arriving on the expiry cycle still counts as success.
                if (tgt_ready) begin
                    done    = 1'b1;
                    state_n = ST_RESP;
                end else if (cnt == CNT_LAST) begin
                    expire  = 1'b1;
                    state_n = ST_RESP;
                end
            end
            ST_RESP:  state_n = ST_DRAIN;
            ST_DRAIN: if (!bus.pcpi_valid) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tgt    <= TGT_NONE;
            insn_q <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            rd_q   <= '0;
            wr_q   <= 1'b0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            if (claim) begin
                tgt    <= cls;
                insn_q <= bus.pcpi_insn;
                rs1_q  <= bus.pcpi_rs1;
                rs2_q  <= bus.pcpi_rs2;
                cnt    <= '0;
            end else if (state == ST_ISSUE) begin
                cnt <= cnt + 1'b1;
            end
            if (done) begin
                wr_q <= tgt_wr;
                rd_q <= tgt_rd;
            end else if (expire) begin
                wr_q  <= 1'b0;
                rd_q  <= '0;
                err_q <= 1'b1;
            end
        end
    end

    assign issue_m = (state == ST_ISSUE) && (tgt == TGT_M);
    assign issue_c = (state == ST_ISSUE) && (tgt == TGT_CUSTOM);
    assign in_resp = (state == ST_RESP);

    assign bus.pcpi_wait  = claim || (state == ST_ISSUE);
    assign bus.pcpi_ready = in_resp;
    assign bus.pcpi_wr    = in_resp && wr_q;
    assign bus.pcpi_rd    = in_resp ? rd_q : '0;

    assign bus.m_valid       = issue_m;
    assign bus.m_instruction = issue_m ? insn_q : '0;
    assign bus.m_rs1         = issue_m ? rs1_q  : '0;
    assign bus.m_rs2         = issue_m ? rs2_q  : '0;

    assign bus.c_valid       = issue_c;
    assign bus.c_instruction = issue_c ? insn_q : '0;
    assign bus.c_rs1         = issue_c ? rs1_q  : '0;
    assign bus.c_rs2         = issue_c ? rs2_q  : '0;

    assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_pcpi_dispatch.sv
// Directed self-checking bench for pcpi_dispatch (TIMEOUT_CYCLES = 8).
module tb_pcpi_dispatch;
    import pcpi_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int unsigned total  = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    pcpi_dispatch_if bus();

    pcpi_dispatch #(
        .TIMEOUT_CYCLES(8),
        .CUSTOM_OPCODE (7'b0001011)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.pcpi_valid = 0; bus.pcpi_insn = '0; bus.pcpi_rs1 = '0; bus.pcpi_rs2 = '0;
        bus.m_wr = 0; bus.m_rd = '0; bus.m_busy = 0; bus.m_ready = 0;
        bus.c_wr = 0; bus.c_rd = '0; bus.c_busy = 0; bus.c_ready = 0;
    endtask

    task automatic request(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        bus.pcpi_valid = 1; bus.pcpi_insn = insn; bus.pcpi_rs1 = a; bus.pcpi_rs2 = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        reset = 1;
        cyc(); cyc();
        reset = 0;
        settle();
        chk("rst_wait",  32'(bus.pcpi_wait),   0);
        chk("rst_ready", 32'(bus.pcpi_ready),  0);
        chk("rst_rd",    bus.pcpi_rd,          0);
        chk("rst_mv",    32'(bus.m_valid),     0);
        chk("rst_cv",    32'(bus.c_valid),     0);
        chk("rst_err",   32'(bus.timeout_err), 0);

        // MUL x?, 7*6; M ready on third ISSUE cycle
        request(32'h02208033, 7, 6);
        settle();
        chk("mul_wait_idle", 32'(bus.pcpi_wait), 1);
        chk("mul_mv_idle",   32'(bus.m_valid),   0);
        cyc();
        chk("mul_mv",   32'(bus.m_valid), 1);
        chk("mul_insn", bus.m_instruction, 32'h02208033);
        chk("mul_rs1",  bus.m_rs1, 7);
        chk("mul_rs2",  bus.m_rs2, 6);
        chk("mul_cv",   32'(bus.c_valid), 0);
        cyc();
        chk("mul_mv2",  32'(bus.m_valid), 1);
        chk("mul_wait2", 32'(bus.pcpi_wait), 1);
        cyc();
        chk("mul_mv3",  32'(bus.m_valid), 1);
        chk("mul_cv3",  32'(bus.c_valid), 0);
        bus.m_ready = 1; bus.m_wr = 1; bus.m_rd = 42;
        bus.c_ready = 1; bus.c_wr = 1; bus.c_rd = 32'h0BAD0BAD;
        cyc();
        bus.m_ready = 0; bus.m_wr = 0; bus.m_rd = '0;
        bus.c_ready = 0; bus.c_wr = 0; bus.c_rd = '0;
        settle();
        chk("mul_ready", 32'(bus.pcpi_ready), 1);
        chk("mul_wr",    32'(bus.pcpi_wr), 1);
        chk("mul_rd",    bus.pcpi_rd, 42);
        chk("mul_mv_resp", 32'(bus.m_valid), 0);
        chk("mul_wait_resp", 32'(bus.pcpi_wait), 0);
        // valid held three cycles past ready: no second dispatch
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("drain_ready", 32'(bus.pcpi_ready), 0);
            chk("drain_rd",    bus.pcpi_rd, 0);
            chk("drain_mv",    32'(bus.m_valid), 0);
            chk("drain_wait",  32'(bus.pcpi_wait), 0);
        end
        bus.pcpi_valid = 0;
        cyc();
        chk("drain_idle", 32'(dut.state), 32'(ST_IDLE));

        // custom-0, ready on ISSUE cycle 0, M response must be ignored
        request(32'h0000000B, 1, 2);
        cyc();
        chk("cus_cv",   32'(bus.c_valid), 1);
        chk("cus_mv",   32'(bus.m_valid), 0);
        chk("cus_insn", bus.c_instruction, 32'h0000000B);
        bus.c_ready = 1; bus.c_wr = 1; bus.c_rd = 32'hDEADBEEF;
        bus.m_ready = 1; bus.m_wr = 1; bus.m_rd = 32'h00001234;
        cyc();
        bus.c_ready = 0; bus.c_wr = 0; bus.c_rd = '0;
        bus.m_ready = 0; bus.m_wr = 0; bus.m_rd = '0;
        settle();
        chk("cus_ready", 32'(bus.pcpi_ready), 1);
        chk("cus_rd",    bus.pcpi_rd, 32'hDEADBEEF);
        chk("cus_wr",    32'(bus.pcpi_wr), 1);
        chk("cus_cv_resp", 32'(bus.c_valid), 0);
        bus.pcpi_valid = 0;
        cyc();
        chk("cus_ready_off", 32'(bus.pcpi_ready), 0);
        cyc();

        // ADD: not ours, nothing happens for 20 cycles
        request(32'h00208033, 3, 4);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin bus.m_ready = 1; bus.m_wr = 1; bus.m_rd = 99; end
            if (i == 6) begin bus.m_ready = 0; bus.m_wr = 0; bus.m_rd = '0; end
            settle();
            chk("add_wait",  32'(bus.pcpi_wait),  0);
            chk("add_mv",    32'(bus.m_valid),    0);
            chk("add_cv",    32'(bus.c_valid),    0);
            chk("add_ready", 32'(bus.pcpi_ready), 0);
            cyc();
        end
        bus.pcpi_valid = 0;
        cyc();

        // ready on the expiry cycle wins
        request(32'h02208033, 2, 3);
        cyc();
        for (int i = 0; i < 7; i++) cyc();
        chk("tie_mv_last", 32'(bus.m_valid), 1);
        bus.m_ready = 1; bus.m_wr = 1; bus.m_rd = 32'h55;
        cyc();
        bus.m_ready = 0; bus.m_wr = 0; bus.m_rd = '0;
        settle();
        chk("tie_ready", 32'(bus.pcpi_ready), 1);
        chk("tie_rd",    bus.pcpi_rd, 32'h55);
        chk("tie_wr",    32'(bus.pcpi_wr), 1);
        chk("tie_err",   32'(bus.timeout_err), 0);
        bus.pcpi_valid = 0;
        cyc(); cyc();

        // timeout: M never ready
        request(32'h02208033, 9, 9);
        cyc();
        for (int i = 0; i < 8; i++) begin
            chk("to_mv", 32'(bus.m_valid), 1);
            cyc();
        end
        chk("to_ready", 32'(bus.pcpi_ready), 1);
        chk("to_wr",    32'(bus.pcpi_wr), 0);
        chk("to_rd",    bus.pcpi_rd, 0);
        chk("to_err",   32'(bus.timeout_err), 1);
        chk("to_mv_off", 32'(bus.m_valid), 0);
        // late ready from the aborted unit is ignored
        bus.m_ready = 1; bus.m_wr = 1; bus.m_rd = 77;
        bus.pcpi_valid = 0;
        cyc();
        bus.m_ready = 0; bus.m_wr = 0; bus.m_rd = '0;
        settle();
        chk("to_late_ready", 32'(bus.pcpi_ready), 0);
        chk("to_late_mv",    32'(bus.m_valid), 0);
        cyc(); cyc();
        chk("to_err_sticky", 32'(bus.timeout_err), 1);
        chk("to_mv_quiet",   32'(bus.m_valid), 0);

        // reset during the second ISSUE cycle
        request(32'h02208033, 4, 4);
        cyc();
        cyc();
        chk("rmid_mv", 32'(bus.m_valid), 1);
        reset = 1;
        cyc();
        settle();
        chk("rmid_state", 32'(dut.state), 32'(ST_IDLE));
        chk("rmid_wait",  32'(bus.pcpi_wait), 0);
        chk("rmid_ready", 32'(bus.pcpi_ready), 0);
        chk("rmid_wr",    32'(bus.pcpi_wr), 0);
        chk("rmid_rd",    bus.pcpi_rd, 0);
        chk("rmid_mv",    32'(bus.m_valid), 0);
        chk("rmid_minsn", bus.m_instruction, 0);
        chk("rmid_cv",    32'(bus.c_valid), 0);
        chk("rmid_err",   32'(bus.timeout_err), 0);
        reset = 0;
        bus.pcpi_valid = 0;
        cyc();
        request(32'h02208033, 3, 5);
        cyc();
        chk("post_mv",  32'(bus.m_valid), 1);
        chk("post_rs1", bus.m_rs1, 3);
        bus.m_ready = 1; bus.m_wr = 1; bus.m_rd = 15;
        cyc();
        bus.m_ready = 0; bus.m_wr = 0; bus.m_rd = '0;
        settle();
        chk("post_ready", 32'(bus.pcpi_ready), 1);
        chk("post_rd",    bus.pcpi_rd, 15);
        chk("post_err",   32'(bus.timeout_err), 0);
        bus.pcpi_valid = 0;
        cyc(); cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
